i2s_tx_serializer: RTL and testbench

- I2S slave transmitter at the output end of the chorus chain, the counterpart of the RX path that feeds the DSP.
- Takes mixed mono packets plus their change strobe and serializes them MSB-first onto the I2S SD line.
- Left and right slots carry the same sample. SCLK/LRCLK come from the MCU and are oversampled in the fast DSP clock domain.

---
 rtl/i2s_tx_serializer.sv | 190 +++++++++++++++++++
 tb/tb_i2s_tx_serializer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx_serializer.sv
// I2S slave transmitter: oversamples MCU-driven SCLK/LRCLK in the DSP clock domain
// and shifts mono samples MSB-first into both the left and right slots (Philips timing).
module i2s_tx_serializer #(
  parameter int PKT_WIDTH   = 16,
  parameter int SLOT_BITS   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 sclk_i,
  input  logic                 lrclk_i,
  input  logic [PKT_WIDTH-1:0] pkt_i,
  input  logic                 pktChanged_i,
  output logic                 sd_o,
  output logic                 pktReq_o,
  output logic                 underrun_o,
  output logic                 overrun_o,
  output logic                 frameErr_o
);

  localparam int CNT_W = $clog2(SLOT_BITS + 1);

  typedef enum logic {
    WAIT_SYNC,
    RUN
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] lrclk_sync_q, lrclk_sync_d;
  logic                   sclk_dly_q, sclk_dly_d;
  logic                   sclk_s, lrclk_s, sclk_fall;

  state_t                 state_q, state_d;
  logic [SLOT_BITS-1:0]   shift_q, shift_d;
  logic [PKT_WIDTH-1:0]   hold_q, hold_d;
  logic [PKT_WIDTH-1:0]   word_q, word_d;
  logic                   pending_q, pending_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [CNT_W:0]         cnt_inc;
  logic                   lr_prev_q, lr_prev_d;
  logic                   sd_q, sd_d;
  logic                   pkt_req_q, pkt_req_d;
  logic                   underrun_q, underrun_d;
  logic                   overrun_q, overrun_d;
  logic                   frame_err_q, frame_err_d;
  logic                   do_left, do_right;

  // Left-align a sample in the slot-wide shift register; padding bits are zero.
  function automatic logic [SLOT_BITS-1:0] align_word(input logic [PKT_WIDTH-1:0] w);
    logic [SLOT_BITS-1:0] r;
    r = '0;
    r[SLOT_BITS-1 -: PKT_WIDTH] = w;
    return r;
  endfunction

  always_comb begin
    sclk_sync_d  = (sclk_sync_q << 1) | SYNC_STAGES'(sclk_i);
    lrclk_sync_d = (lrclk_sync_q << 1) | SYNC_STAGES'(lrclk_i);
    sclk_s       = sclk_sync_q[SYNC_STAGES-1];
    lrclk_s      = lrclk_sync_q[SYNC_STAGES-1];
    sclk_dly_d   = sclk_s;
    sclk_fall    = sclk_dly_q & ~sclk_s;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sclk_sync_q  <= '0;
      lrclk_sync_q <= '0;
      sclk_dly_q   <= 1'b0;
    end else begin
      sclk_sync_q  <= sclk_sync_d;
      lrclk_sync_q <= lrclk_sync_d;
      sclk_dly_q   <= sclk_dly_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    word_d      = word_q;
    pending_d   = pending_q;
    bit_cnt_d   = bit_cnt_q;
    lr_prev_d   = lr_prev_q;
    sd_d        = sd_q;
    pkt_req_d   = 1'b0;
    underrun_d  = 1'b0;
    overrun_d   = 1'b0;
    frame_err_d = 1'b0;
    do_left     = 1'b0;
    do_right    = 1'b0;
    cnt_inc     = (CNT_W+1)'(bit_cnt_q) + (CNT_W+1)'(1);

    if (pktChanged_i) begin
      hold_d    = pkt_i;
      pending_d = 1'b1;
    end

    if (sclk_fall) begin
      lr_prev_d = lrclk_s;
      case (state_q)
        WAIT_SYNC: begin
          sd_d    = 1'b0;
          shift_d = '0;
          if (lr_prev_q && !lrclk_s) begin
            do_left = 1'b1;
            state_d = RUN;
          end
        end
        RUN: begin
          sd_d    = shift_q[SLOT_BITS-1];
          shift_d = shift_q << 1;
          if (bit_cnt_q != CNT_W'(SLOT_BITS)) begin
            bit_cnt_d = cnt_inc[CNT_W-1:0];
          end
          if (lrclk_s != lr_prev_q) begin
            if (cnt_inc != (CNT_W+1)'(SLOT_BITS)) begin
              frame_err_d = 1'b1;
            end
            do_left  = ~lrclk_s;
            do_right = lrclk_s;
          end
        end
        default: state_d = WAIT_SYNC;
      endcase
    end

    // A strobe landing on the load cycle bypasses the hold register entirely.
    if (do_left) begin
      bit_cnt_d = '0;
      pkt_req_d = 1'b1;
      if (pktChanged_i) begin
        word_d    = pkt_i;
        pending_d = 1'b0;
      end else if (pending_q) begin
        word_d    = hold_q;
        pending_d = 1'b0;
      end else begin
        underrun_d = 1'b1;
      end
      shift_d = align_word(word_d);
    end

    if (do_right) begin
      bit_cnt_d = '0;
      shift_d   = align_word(word_q);
    end

    if (pktChanged_i && pending_q && !do_left) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= WAIT_SYNC;
      shift_q     <= '0;
      hold_q      <= '0;
      word_q      <= '0;
      pending_q   <= 1'b0;
      bit_cnt_q   <= '0;
      lr_prev_q   <= 1'b0;
      sd_q        <= 1'b0;
      pkt_req_q   <= 1'b0;
      underrun_q  <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      word_q      <= word_d;
      pending_q   <= pending_d;
      bit_cnt_q   <= bit_cnt_d;
      lr_prev_q   <= lr_prev_d;
      sd_q        <= sd_d;
      pkt_req_q   <= pkt_req_d;
      underrun_q  <= underrun_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign sd_o       = sd_q;
  assign pktReq_o   = pkt_req_q;
  assign underrun_o = underrun_q;
  assign overrun_o  = overrun_q;
  assign frameErr_o = frame_err_q;

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Directed bench for i2s_tx_serializer: a 16/16-slot instance driven from a frame table
// plus hand-written reset/concurrent-strobe sequences, and a 24-bit-slot instance for padding.
module tb_i2s_tx_serializer;

  logic        clk = 1'b0;
  logic        reset16, reset24;
  logic        sclk, lrclk;
  logic [15:0] pkt;
  logic        pkt_changed;
  logic        sd16, req16, und16, ovr16, err16;
  logic        sd24, req24, und24, ovr24, err24;

  int checks = 0;
  int errors = 0;
  int n_req16 = 0, n_und16 = 0, n_ovr16 = 0, n_err16 = 0;
  int n_req24 = 0, n_err24 = 0;

  logic [127:0] rx16, rx24;

  typedef struct {
    string       name;
    int          n_strobes;
    logic [15:0] pkt_a;
    logic [15:0] pkt_b;
    int          n_left;
    int          n_right;
    logic [15:0] exp_left;
    logic [15:0] exp_prev_right;
    int          exp_req;
    int          exp_und;
    int          exp_ovr;
    int          exp_err;
  } vec_t;

  vec_t vecs[7];
  int   s_req, s_und, s_ovr, s_err;

  i2s_tx_serializer dut (
    .clk_i(clk), .reset_i(reset16), .sclk_i(sclk), .lrclk_i(lrclk),
    .pkt_i(pkt), .pktChanged_i(pkt_changed), .sd_o(sd16), .pktReq_o(req16),
    .underrun_o(und16), .overrun_o(ovr16), .frameErr_o(err16)
  );

  i2s_tx_serializer #(.PKT_WIDTH(16), .SLOT_BITS(24), .SYNC_STAGES(2)) dut24 (
    .clk_i(clk), .reset_i(reset24), .sclk_i(sclk), .lrclk_i(lrclk),
    .pkt_i(pkt), .pktChanged_i(pkt_changed), .sd_o(sd24), .pktReq_o(req24),
    .underrun_o(und24), .overrun_o(ovr24), .frameErr_o(err24)
  );

  always #5 clk = ~clk;

  // Pulse outputs are tallied continuously so frame-level deltas can be checked.
  always @(negedge clk) begin
    if (req16) n_req16++;
    if (und16) n_und16++;
    if (ovr16) n_ovr16++;
    if (err16) n_err16++;
    if (req24) n_req24++;
    if (err24) n_err24++;
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic strobe(input logic [15:0] value);
    @(negedge clk);
    pkt_changed = 1'b1;
    pkt         = value;
    @(negedge clk);
    pkt_changed = 1'b0;
  endtask

  // One SCLK period, 4 clk low then 4 clk high; sd is captured just before the rising edge.
  task automatic sclk_cycle(input logic lr, input logic stb, input logic [15:0] value);
    @(negedge clk);
    sclk  = 1'b0;
    lrclk = lr;
    @(negedge clk);
    @(negedge clk);
    if (stb) begin
      pkt_changed = 1'b1;
      pkt         = value;
    end
    @(negedge clk);
    pkt_changed = 1'b0;
    @(negedge clk);
    rx16 = {rx16[126:0], sd16};
    rx24 = {rx24[126:0], sd24};
    sclk = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic run_frame(input int n_left, input int n_right, input logic load_stb,
                           input logic [15:0] value);
    for (int i = 0; i < n_left; i++) sclk_cycle(1'b0, load_stb && (i == 0), value);
    for (int i = 0; i < n_right; i++) sclk_cycle(1'b1, 1'b0, 16'h0);
  endtask

  task automatic apply_stimulus(input vec_t v);
    s_req = n_req16;
    s_und = n_und16;
    s_ovr = n_ovr16;
    s_err = n_err16;
    if (v.n_strobes > 0) strobe(v.pkt_a);
    if (v.n_strobes > 1) strobe(v.pkt_b);
    run_frame(v.n_left, v.n_right, 1'b0, 16'h0);
  endtask

  initial begin
    vecs[0] = '{"basic",     1, 16'hA5C3, 16'h0000, 16, 16, 16'hA5C3, 16'h0000, 1, 0, 0, 0};
    vecs[1] = '{"underrun",  0, 16'h0000, 16'h0000, 16, 16, 16'hA5C3, 16'hA5C3, 1, 1, 0, 0};
    vecs[2] = '{"overrun",   2, 16'h1234, 16'h8001, 16, 16, 16'h8001, 16'hA5C3, 1, 0, 1, 0};
    vecs[3] = '{"new_word",  1, 16'h7F00, 16'h0000, 16, 16, 16'h7F00, 16'h8001, 1, 0, 0, 0};
    vecs[4] = '{"short_r",   1, 16'h0F0F, 16'h0000, 16, 12, 16'h0F0F, 16'h7F00, 1, 0, 0, 0};
    vecs[5] = '{"glitch_ld", 1, 16'h3C3C, 16'h0000, 16, 16, 16'h3C3C, 16'hF0F0, 1, 0, 0, 1};
    vecs[6] = '{"recovered", 0, 16'h0000, 16'h0000, 16, 16, 16'h3C3C, 16'h3C3C, 1, 1, 0, 0};

    sclk        = 1'b1;
    lrclk       = 1'b1;
    pkt         = 16'h0;
    pkt_changed = 1'b0;
    rx16        = '0;
    rx24        = '0;
    reset16     = 1'b1;
    reset24     = 1'b1;
    repeat (4) @(negedge clk);
    check_output("reset_sd", sd16, 0);
    check_output("reset_pulses", {req16, und16, ovr16, err16}, 0);
    reset16 = 1'b0;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 4; i++) sclk_cycle(1'b1, 1'b0, 16'h0);
    check_output("wait_sync_req", n_req16, 0);

    for (int i = 0; i < 7; i++) begin
      apply_stimulus(vecs[i]);
      check_output({vecs[i].name, "_left"}, rx16[vecs[i].n_right-1 +: 16], vecs[i].exp_left);
      check_output({vecs[i].name, "_prev_right"},
                   rx16[vecs[i].n_left+vecs[i].n_right-1 +: 16], vecs[i].exp_prev_right);
      check_output({vecs[i].name, "_req"}, n_req16 - s_req, vecs[i].exp_req);
      check_output({vecs[i].name, "_und"}, n_und16 - s_und, vecs[i].exp_und);
      check_output({vecs[i].name, "_ovr"}, n_ovr16 - s_ovr, vecs[i].exp_ovr);
      check_output({vecs[i].name, "_err"}, n_err16 - s_err, vecs[i].exp_err);
    end

    // Reset during bit 7 of a left slot carrying all ones.
    strobe(16'hFFFF);
    for (int i = 0; i < 8; i++) sclk_cycle(1'b0, 1'b0, 16'h0);
    check_output("pre_reset_sd", sd16, 1);
    @(negedge clk);
    reset16 = 1'b1;
    #1;
    check_output("async_reset_sd", sd16, 0);
    repeat (2) @(negedge clk);
    reset16 = 1'b0;
    rx16    = '0;
    s_req   = n_req16;
    for (int i = 0; i < 8; i++) sclk_cycle(1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 16; i++) sclk_cycle(1'b1, 1'b0, 16'h0);
    check_output("resync_silent", $countones(rx16), 0);
    check_output("resync_no_req", n_req16 - s_req, 0);

    // Strobe arriving in the very cycle of the left load.
    s_req = n_req16;
    s_und = n_und16;
    s_ovr = n_ovr16;
    run_frame(16, 16, 1'b1, 16'h2222);
    check_output("conc_left", rx16[30:15], 16'h2222);
    check_output("conc_req", n_req16 - s_req, 1);
    check_output("conc_und", n_und16 - s_und, 0);
    check_output("conc_ovr", n_ovr16 - s_ovr, 0);
    run_frame(16, 16, 1'b0, 16'h0);
    check_output("conc_prev_right", rx16[46:31], 16'h2222);
    check_output("conc_hold_left", rx16[30:15], 16'h2222);

    // Padding on the 24-bit-slot instance.
    reset16 = 1'b1;
    reset24 = 1'b0;
    rx24    = '0;
    repeat (4) @(negedge clk);
    strobe(16'hFFFF);
    for (int i = 0; i < 4; i++) sclk_cycle(1'b1, 1'b0, 16'h0);
    s_req = n_req24;
    s_err = n_err24;
    run_frame(24, 24, 1'b0, 16'h0);
    check_output("pad_left", rx24[46:23], 24'hFFFF00);
    run_frame(24, 24, 1'b0, 16'h0);
    check_output("pad_prev_right", rx24[70:47], 24'hFFFF00);
    check_output("pad_left2", rx24[46:23], 24'hFFFF00);
    check_output("pad_req", n_req24 - s_req, 2);
    check_output("pad_err", n_err24 - s_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
